// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared constants for the VGA raster generator: default
//               640x480@60 Hz timing, counter width and legality limits,
//               sync polarity, delay-line reset fill values, and helpers
//               that derive line/frame totals from the porch/sync widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Default 640x480@60 Hz timing for a 25 MHz pixel clock
    localparam int c_DEF_H_VISIBLE = 640;
    localparam int c_DEF_H_FP      = 16;
    localparam int c_DEF_H_SYNC    = 96;
    localparam int c_DEF_H_BP      = 48;
    localparam int c_DEF_V_VISIBLE = 480;
    localparam int c_DEF_V_FP      = 10;
    localparam int c_DEF_V_SYNC    = 2;
    localparam int c_DEF_V_BP      = 33;
    localparam int c_DEF_PIPE_DLY  = 2;

    // Counter width and the largest totals / delay it can represent
    localparam int c_CNT_W        = 10;
    localparam int c_MAX_TOTAL    = 1 << c_CNT_W;
    localparam int c_MAX_PIPE_DLY = 7;

    // Both syncs are active-low
    localparam logic SYNC_ACTIVE = 1'b0;

    // Values held by every delay-line stage while in reset
    localparam logic c_HS_FILL    = ~SYNC_ACTIVE;
    localparam logic c_VS_FILL    = ~SYNC_ACTIVE;
    localparam logic c_BLANK_FILL = 1'b0;

    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay_line
// Description : DEPTH x WIDTH shift register with a per-bit reset value.
//               DEPTH = 0 degenerates to a combinational pass-through.
// Ports       : clk      - clock
//               reset_n  - asynchronous active-low reset (loads RST_VAL)
//               i_d      - data in
//               o_q      - data out, i_d delayed DEPTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_passthru
            // Clock and reset have no load here; fold them into a sink
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ reset_n;
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. DrawX/DrawY are the pixel and
//               line counters; blank/hs/vs/line_start/frame_start are
//               registered decodes of the next counter value so they line up
//               with the counters. hs_d/vs_d/blank_d are the same strobes
//               delayed PIPE_DLY cycles to match the drawers' colour latency.
// Ports       : vga_clk     - pixel clock
//               reset_n     - asynchronous active-low reset
//               DrawX/DrawY - current column / line
//               blank       - 1 on visible pixels
//               hs/vs       - active-low syncs aligned with DrawX/DrawY
//               hs_d/vs_d/blank_d - syncs/blank delayed PIPE_DLY cycles
//               line_start  - pulse at DrawX == 0
//               frame_start - pulse at DrawX == 0 and DrawY == 0
//               frame_count - frames started since reset, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_DEF_H_VISIBLE,
    parameter int H_FP      = c_DEF_H_FP,
    parameter int H_SYNC    = c_DEF_H_SYNC,
    parameter int H_BP      = c_DEF_H_BP,
    parameter int V_VISIBLE = c_DEF_V_VISIBLE,
    parameter int V_FP      = c_DEF_V_FP,
    parameter int V_SYNC    = c_DEF_V_SYNC,
    parameter int V_BP      = c_DEF_V_BP,
    parameter int PIPE_DLY  = c_DEF_PIPE_DLY
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    output logic [c_CNT_W-1:0]  DrawX,
    output logic [c_CNT_W-1:0]  DrawY,
    output logic                blank,
    output logic                hs,
    output logic                vs,
    output logic                hs_d,
    output logic                vs_d,
    output logic                blank_d,
    output logic                line_start,
    output logic                frame_start,
    output logic [15:0]         frame_count
);

    localparam int c_H_TOTAL  = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL  = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int c_HS_START = H_VISIBLE + H_FP;
    localparam int c_HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int c_VS_START = V_VISIBLE + V_FP;
    localparam int c_VS_END   = V_VISIBLE + V_FP + V_SYNC;

    localparam logic [c_CNT_W-1:0] c_H_LAST = c_CNT_W'(c_H_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST = c_CNT_W'(c_V_TOTAL - 1);

    localparam logic c_PARAMS_OK = (c_H_TOTAL >= 1) && (c_H_TOTAL <= c_MAX_TOTAL) &&
                                   (c_V_TOTAL >= 1) && (c_V_TOTAL <= c_MAX_TOTAL) &&
                                   (PIPE_DLY >= 0) && (PIPE_DLY <= c_MAX_PIPE_DLY);

    logic [c_CNT_W-1:0] r_x;
    logic [c_CNT_W-1:0] r_y;
    logic               r_blank;
    logic               r_hs;
    logic               r_vs;
    logic               r_line_start;
    logic               r_frame_start;
    logic [15:0]        r_frame_count;

    logic [c_CNT_W-1:0] w_x_nxt;
    logic [c_CNT_W-1:0] w_y_nxt;
    logic               w_x_wrap;
    int                 w_x_int;
    int                 w_y_int;
    logic               w_frame_nxt;
    logic [2:0]         w_dly_q;

    // Next counter value; every decode below looks at it so the registered
    // strobes describe the same pixel as the registered counters.
    always_comb begin
        w_x_wrap = (r_x == c_H_LAST);
        w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = (r_y == c_V_LAST) ? '0 : r_y + 1'b1;
        end
        // Compare in 32 bits so a sync edge at exactly 1024 still works
        w_x_int     = int'(w_x_nxt);
        w_y_int     = int'(w_y_nxt);
        w_frame_nxt = (w_x_nxt == '0) && (w_y_nxt == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= c_H_LAST;
            r_y           <= c_V_LAST;
            r_blank       <= 1'b0;
            r_hs          <= ~SYNC_ACTIVE;
            r_vs          <= ~SYNC_ACTIVE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_blank       <= (w_x_int < H_VISIBLE) && (w_y_int < V_VISIBLE);
            r_hs          <= ((w_x_int >= c_HS_START) && (w_x_int < c_HS_END)) ?
                             SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs          <= ((w_y_int >= c_VS_START) && (w_y_int < c_VS_END)) ?
                             SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_line_start  <= (w_x_nxt == '0);
            r_frame_start <= w_frame_nxt;
            if (w_frame_nxt) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Parameter legality guard for simulation
    always_ff @(posedge vga_clk) begin
        assert (c_PARAMS_OK)
            else $error("vga_timing_gen: totals must be 1..1024 and PIPE_DLY 0..7");
    end

    sync_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL ({c_HS_FILL, c_VS_FILL, c_BLANK_FILL})
    ) u_sync_dly (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .i_d     ({r_hs, r_vs, r_blank}),
        .o_q     (w_dly_q)
    );

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;
    assign hs_d        = w_dly_q[2];
    assign vs_d        = w_dly_q[1];
    assign blank_d     = w_dly_q[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen. Four
//               instances share clock and reset: default timing with
//               PIPE_DLY=2 and PIPE_DLY=0, a 7x5 raster, and a 1x1 raster
//               whose frame counter wraps within 65536 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 vga_clk = ~vga_clk;

    // Default timing, PIPE_DLY = 2
    logic [9:0] a_x, a_y;
    logic a_blank, a_hs, a_vs, a_hs_d, a_vs_d, a_blank_d, a_ls, a_fs;
    logic [15:0] a_fc;
    // Default timing, PIPE_DLY = 0
    logic [9:0] z_x, z_y;
    logic z_blank, z_hs, z_vs, z_hs_d, z_vs_d, z_blank_d, z_ls, z_fs;
    logic [15:0] z_fc;
    // Small 7x5 raster
    logic [9:0] s_x, s_y;
    logic s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_blank_d, s_ls, s_fs;
    logic [15:0] s_fc;
    // Tiny 1x1 raster
    logic [9:0] t_x, t_y;
    logic t_blank, t_hs, t_vs, t_hs_d, t_vs_d, t_blank_d, t_ls, t_fs;
    logic [15:0] t_fc;

    vga_timing_gen #(.PIPE_DLY(2)) u_dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y),
        .blank(a_blank), .hs(a_hs), .vs(a_vs), .hs_d(a_hs_d), .vs_d(a_vs_d),
        .blank_d(a_blank_d), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

    vga_timing_gen #(.PIPE_DLY(0)) u_dut_z (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y),
        .blank(z_blank), .hs(z_hs), .vs(z_vs), .hs_d(z_hs_d), .vs_d(z_vs_d),
        .blank_d(z_blank_d), .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc));

    vga_timing_gen #(.H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DLY(2)) u_dut_s (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y),
        .blank(s_blank), .hs(s_hs), .vs(s_vs), .hs_d(s_hs_d), .vs_d(s_vs_d),
        .blank_d(s_blank_d), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

    vga_timing_gen #(.H_VISIBLE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
                     .V_VISIBLE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .PIPE_DLY(1)) u_dut_t (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(t_x), .DrawY(t_y),
        .blank(t_blank), .hs(t_hs), .vs(t_vs), .hs_d(t_hs_d), .vs_d(t_vs_d),
        .blank_d(t_blank_d), .line_start(t_ls), .frame_start(t_fs), .frame_count(t_fc));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_x"},       32'(a_x), 32'd799);
        chk({tag, "_y"},       32'(a_y), 32'd524);
        chk({tag, "_blank"},   32'(a_blank), 32'd0);
        chk({tag, "_hs"},      32'(a_hs), 32'd1);
        chk({tag, "_vs"},      32'(a_vs), 32'd1);
        chk({tag, "_ls"},      32'(a_ls), 32'd0);
        chk({tag, "_fs"},      32'(a_fs), 32'd0);
        chk({tag, "_fc"},      32'(a_fc), 32'd0);
        chk({tag, "_hs_d"},    32'(a_hs_d), 32'd1);
        chk({tag, "_vs_d"},    32'(a_vs_d), 32'd1);
        chk({tag, "_blank_d"}, 32'(a_blank_d), 32'd0);
    endtask

    initial begin
        logic hh1, hh2, vh1, vh2, bh1, bh2;
        int n_hs_low, hs_first, hs_last, n_vs_low_a, n_dly_bad, n_zero_bad;
        int n_svs, n_svs_bad, n_sbl, n_sbl_bad, n_shs, n_shs_bad, n_sfs, fs_prev, fs_period;

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk_reset_values("rst");
        chk("rst_z_hs_d", 32'(z_hs_d), 32'd1);

        // ---------------- release, line 0 sweep ----------------
        hh1 = 1'b1; hh2 = 1'b1; vh1 = 1'b1; vh2 = 1'b1; bh1 = 1'b0; bh2 = 1'b0;
        n_hs_low = 0; hs_first = -1; hs_last = -1; n_vs_low_a = 0;
        n_dly_bad = 0; n_zero_bad = 0;
        reset_n = 1'b1;
        for (int c = 1; c <= 801; c++) begin
            @(negedge vga_clk);
            if (c == 1) begin
                chk("first_x",  32'(a_x), 32'd0);
                chk("first_y",  32'(a_y), 32'd0);
                chk("first_blank", 32'(a_blank), 32'd1);
                chk("first_hs", 32'(a_hs), 32'd1);
                chk("first_vs", 32'(a_vs), 32'd1);
                chk("first_fs", 32'(a_fs), 32'd1);
                chk("first_ls", 32'(a_ls), 32'd1);
                chk("first_fc", 32'(a_fc), 32'd1);
            end
            if (c <= 2) begin
                chk("fill_hs_d",    32'(a_hs_d), 32'd1);
                chk("fill_vs_d",    32'(a_vs_d), 32'd1);
                chk("fill_blank_d", 32'(a_blank_d), 32'd0);
            end
            if (a_x == 10'd639 && a_y == 10'd0) chk("blank_x639", 32'(a_blank), 32'd1);
            if (a_x == 10'd640 && a_y == 10'd0) chk("blank_x640", 32'(a_blank), 32'd0);
            if (a_hs === 1'b0) begin
                n_hs_low++;
                if (hs_first < 0) hs_first = int'(a_x);
                hs_last = int'(a_x);
            end
            if (a_vs !== 1'b1) n_vs_low_a++;
            if (a_hs_d !== hh2 || a_vs_d !== vh2 || a_blank_d !== bh2) n_dly_bad++;
            if (z_hs_d !== z_hs || z_vs_d !== z_vs || z_blank_d !== z_blank) n_zero_bad++;
            hh2 = hh1; hh1 = a_hs;
            vh2 = vh1; vh1 = a_vs;
            bh2 = bh1; bh1 = a_blank;
        end
        chk("wrap_x",  32'(a_x), 32'd0);
        chk("wrap_y",  32'(a_y), 32'd1);
        chk("wrap_ls", 32'(a_ls), 32'd1);
        chk("wrap_fs", 32'(a_fs), 32'd0);
        chk("wrap_fc", 32'(a_fc), 32'd1);
        chk("hs_low_count", 32'(n_hs_low), 32'd96);
        chk("hs_low_first", 32'(hs_first), 32'd656);
        chk("hs_low_last",  32'(hs_last), 32'd751);
        chk("vs_high_line0", 32'(n_vs_low_a), 32'd0);
        chk("delay2_mismatches", 32'(n_dly_bad), 32'd0);
        chk("delay0_mismatches", 32'(n_zero_bad), 32'd0);

        // ---------------- asynchronous mid-line reset ----------------
        repeat (300) @(negedge vga_clk);
        chk("pre_rst_x", 32'(a_x), 32'd300);
        chk("pre_rst_y", 32'(a_y), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("async_rst");
        repeat (2) @(negedge vga_clk);
        chk("held_rst_x", 32'(a_x), 32'd799);

        // ---------------- restart + small raster over two frames ----------------
        n_svs = 0; n_svs_bad = 0; n_sbl = 0; n_sbl_bad = 0; n_shs = 0; n_shs_bad = 0;
        n_sfs = 0; fs_prev = -1; fs_period = -1;
        reset_n = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge vga_clk);
            if (c == 1) begin
                chk("restart_x",  32'(a_x), 32'd0);
                chk("restart_y",  32'(a_y), 32'd0);
                chk("restart_fs", 32'(a_fs), 32'd1);
                chk("restart_fc", 32'(a_fc), 32'd1);
                chk("small_first_fc", 32'(s_fc), 32'd1);
            end
            if (s_vs === 1'b0) begin
                n_svs++;
                if (s_y !== 10'd3) n_svs_bad++;
            end
            if (s_blank === 1'b1) begin
                n_sbl++;
                if (s_y >= 10'd2 || s_x >= 10'd4) n_sbl_bad++;
            end
            if (s_hs === 1'b0) begin
                n_shs++;
                if (s_x !== 10'd5) n_shs_bad++;
            end
            if (s_fs === 1'b1) begin
                n_sfs++;
                if (fs_prev >= 0) fs_period = c - fs_prev;
                fs_prev = c;
                if (c == 36) chk("small_fc_frame2", 32'(s_fc), 32'd2);
            end
        end
        chk("small_vs_low_cycles", 32'(n_svs), 32'd14);
        chk("small_vs_wrong_line", 32'(n_svs_bad), 32'd0);
        chk("small_blank_cycles",  32'(n_sbl), 32'd16);
        chk("small_blank_outside", 32'(n_sbl_bad), 32'd0);
        chk("small_hs_low_cycles", 32'(n_shs), 32'd10);
        chk("small_hs_wrong_x",    32'(n_shs_bad), 32'd0);
        chk("small_fs_count",      32'(n_sfs), 32'd2);
        chk("small_fs_period",     32'(fs_period), 32'd35);
        chk("small_fc_end",        32'(s_fc), 32'd2);

        // ---------------- frame_count wrap on the 1x1 raster ----------------
        repeat (65535 - 70) @(negedge vga_clk);
        chk("tiny_fc_ffff", 32'(t_fc), 32'h0000_FFFF);
        @(negedge vga_clk);
        chk("tiny_fc_wrap0", 32'(t_fc), 32'd0);
        chk("tiny_fs_at_wrap", 32'(t_fs), 32'd1);
        chk("long_run_x", 32'(a_x), 32'd735);
        chk("long_run_y", 32'(a_y), 32'd81);
        chk("long_run_hs", 32'(a_hs), 32'd0);
        chk("small_fc_long", 32'(s_fc), 32'd1873);
        @(negedge vga_clk);
        chk("tiny_fc_after_wrap", 32'(t_fc), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
